// File: rtl/sample_avg_pkg.sv
// Shared constants and FSM encoding for the ADC sample averaging path.
// The capture stage imports the same DW so sample widths stay aligned.
package sample_avg_pkg;
    localparam int DW_DEF       = 12;
    localparam int WIN_LOG2_DEF = 3;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/sample_avg_if.sv
// Sample stream in, averaged result out; master is the producer side.
interface sample_avg_if import sample_avg_pkg::*; #(
    parameter int DW = DW_DEF
) ();
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic          clear;
    logic [DW-1:0] avg_out;
    logic          avg_valid;
    logic          primed;
    logic [DW-1:0] peak_out;

    modport master (
        output sample_in, sample_valid, clear,
        input  avg_out, avg_valid, primed, peak_out
    );

    modport slave (
        input  sample_in, sample_valid, clear,
        output avg_out, avg_valid, primed, peak_out
    );
endinterface

// File: rtl/sample_avg_ring_buf.sv
// Window storage: N x DW registers, one write per cycle, old entry read at the same index.
module ring_buf #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DW         = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DW-1:0]         wdata,
    output logic [DW-1:0]         old
);
    localparam int DEPTH = 2**DEPTH_LOG2;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read-before-write: the entry about to be overwritten is the oldest sample.
    assign old = mem[idx];
endmodule

// File: rtl/sample_avg.sv
// Running mean over the last 2**WIN_LOG2 samples plus peak tracking.
module sample_avg import sample_avg_pkg::*; #(
    parameter int WIN_LOG2 = WIN_LOG2_DEF,
    parameter int DW       = DW_DEF
) (
    input logic         clk,
    input logic         reset,
    sample_avg_if.slave bus
);
    localparam int SW = DW + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] LAST = WIN_LOG2'((2**WIN_LOG2) - 1);

    state_t              state, state_next;
    logic [SW-1:0]       sum, sum_next;
    logic [WIN_LOG2-1:0] wr_idx, fill_cnt;
    logic [DW-1:0]       old, avg_q, peak_q;
    logic                avg_valid_q, primed_q;
    logic                accept, window_done;

    // clear has priority: a coincident sample is dropped.
    assign accept      = bus.sample_valid && !bus.clear;
    assign window_done = (state == RUN) || (fill_cnt == LAST);
    assign sum_next    = sum + SW'(bus.sample_in) - SW'(old);

    ring_buf #(.DEPTH_LOG2(WIN_LOG2), .DW(DW)) u_buf (
        .clk   (clk),
        .reset (reset),
        .flush (bus.clear),
        .we    (accept),
        .idx   (wr_idx),
        .wdata (bus.sample_in),
        .old   (old)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FILL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (accept && fill_cnt == LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = FILL;
        endcase
        if (bus.clear) state_next = FILL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum         <= '0;
            wr_idx      <= '0;
            fill_cnt    <= '0;
            avg_q       <= '0;
            peak_q      <= '0;
            avg_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else if (bus.clear) begin
            sum         <= '0;
            wr_idx      <= '0;
            fill_cnt    <= '0;
            avg_q       <= '0;
            peak_q      <= '0;
            avg_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            avg_valid_q <= accept && window_done;
            primed_q    <= (state_next == RUN);
            if (accept) begin
                sum    <= sum_next;
                wr_idx <= wr_idx + 1'b1;
                avg_q  <= sum_next[SW-1:WIN_LOG2];
                if (bus.sample_in > peak_q) peak_q <= bus.sample_in;
                if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    assign bus.avg_out   = avg_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.primed    = primed_q;
    assign bus.peak_out  = peak_q;
endmodule

// File: tb/tb_sample_avg.sv
// Directed checks of the sample averager at N=8, DW=12.
module tb_sample_avg;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    sample_avg_if #(.DW(12)) bus ();

    sample_avg #(.WIN_LOG2(3), .DW(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Applies inputs for one full cycle, negedge to negedge; outputs are then settled.
    task automatic drive(input logic v, input logic [11:0] d, input logic c);
        bus.sample_valid = v;
        bus.sample_in    = d;
        bus.clear        = c;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.clear        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.clear        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = 12'hABC;
        bus.clear        = 1'b0;
        #2;
        vectors++;
        if ({bus.avg_out, bus.avg_valid, bus.primed, bus.peak_out} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: got avg=%h v=%b p=%b peak=%h, want all 0",
                     bus.avg_out, bus.avg_valid, bus.primed, bus.peak_out);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 12'h0, 1'b0);
        vectors++;
        if (bus.avg_valid !== 1'b0 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL post_release: got v=%b p=%b, want 0 0", bus.avg_valid, bus.primed);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 12'h800, 1'b0);
            if (i < 7) begin
                vectors++;
                if (bus.avg_valid !== 1'b0 || bus.primed !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_early[%0d]: got v=%b p=%b, want 0 0", i, bus.avg_valid, bus.primed);
                end
            end
        end
        vectors++;
        if (bus.avg_valid !== 1'b1 || bus.avg_out !== 12'h800 || bus.primed !== 1'b1) begin
            errors++;
            $display("FAIL fill_done: got v=%b avg=%h p=%b, want 1 800 1", bus.avg_valid, bus.avg_out, bus.primed);
        end
        drive(1'b0, 12'h0, 1'b0);
        vectors++;
        if (bus.avg_valid !== 1'b0 || bus.primed !== 1'b1 || bus.avg_out !== 12'h800) begin
            errors++;
            $display("FAIL idle_hold: got v=%b p=%b avg=%h, want 0 1 800", bus.avg_valid, bus.primed, bus.avg_out);
        end
    endtask

    task automatic test_step();
        drive(1'b1, 12'hFFF, 1'b0);
        vectors++;
        if (bus.avg_valid !== 1'b1 || bus.avg_out !== 12'h8FF || bus.peak_out !== 12'hFFF) begin
            errors++;
            $display("FAIL step: got v=%b avg=%h peak=%h, want 1 8ff fff", bus.avg_valid, bus.avg_out, bus.peak_out);
        end
    endtask

    task automatic test_clear();
        drive(1'b1, 12'h123, 1'b1);
        vectors++;
        if (bus.avg_valid !== 1'b0 || bus.primed !== 1'b0 || bus.avg_out !== 12'h0 || bus.peak_out !== 12'h0) begin
            errors++;
            $display("FAIL clear: got v=%b p=%b avg=%h peak=%h, want 0 0 0 0",
                     bus.avg_valid, bus.primed, bus.avg_out, bus.peak_out);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 12'h010, 1'b0);
            if (i == 6) begin
                vectors++;
                if (bus.avg_valid !== 1'b0 || bus.primed !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_refill7: got v=%b p=%b, want 0 0", bus.avg_valid, bus.primed);
                end
            end
        end
        vectors++;
        if (bus.avg_valid !== 1'b1 || bus.avg_out !== 12'h010 || bus.primed !== 1'b1 || bus.peak_out !== 12'h010) begin
            errors++;
            $display("FAIL clear_refill: got v=%b avg=%h p=%b peak=%h, want 1 010 1 010",
                     bus.avg_valid, bus.avg_out, bus.primed, bus.peak_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 12'h100, 1'b0);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.avg_out, bus.avg_valid, bus.primed, bus.peak_out} !== 26'd0) begin
            errors++;
            $display("FAIL async_reset: got avg=%h v=%b p=%b peak=%h, want all 0",
                     bus.avg_out, bus.avg_valid, bus.primed, bus.peak_out);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 12'h040, 1'b0);
            if (i == 6) begin
                vectors++;
                if (bus.primed !== 1'b0 || bus.avg_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL async_refill7: got p=%b v=%b, want 0 0", bus.primed, bus.avg_valid);
                end
            end
        end
        vectors++;
        if (bus.primed !== 1'b1 || bus.avg_valid !== 1'b1 || bus.avg_out !== 12'h040) begin
            errors++;
            $display("FAIL async_refill: got p=%b v=%b avg=%h, want 1 1 040", bus.primed, bus.avg_valid, bus.avg_out);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        for (int i = 1; i <= 8; i++) drive(1'b1, 12'(i), 1'b0);
        vectors++;
        if (bus.avg_valid !== 1'b1 || bus.avg_out !== 12'd4 || bus.peak_out !== 12'd8) begin
            errors++;
            $display("FAIL ramp8: got v=%b avg=%0d peak=%0d, want 1 4 8", bus.avg_valid, bus.avg_out, bus.peak_out);
        end
        drive(1'b1, 12'd9, 1'b0);
        vectors++;
        if (bus.avg_valid !== 1'b1 || bus.avg_out !== 12'd5) begin
            errors++;
            $display("FAIL ramp9: got v=%b avg=%0d, want 1 5", bus.avg_valid, bus.avg_out);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int bad    = 0;
        do_reset();
        bus.sample_in    = 12'hFFF;
        bus.sample_valid = 1'b1;
        bus.clear        = 1'b0;
        for (int i = 0; i < 21; i++) begin
            if (i == 20) bus.sample_valid = 1'b0;
            @(negedge clk);
            if (bus.avg_valid === 1'b1) begin
                pulses++;
                if (bus.avg_out !== 12'hFFF) bad++;
            end
        end
        vectors++;
        if (pulses != 13 || bad != 0) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses (%0d wrong avg), want 13 pulses of fff", pulses, bad);
        end
        vectors++;
        if (dut.sum !== 15'h7FF8) begin
            errors++;
            $display("FAIL b2b_sum: got %h, want 7ff8", dut.sum);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_step();
        test_clear();
        test_async_reset();
        test_ramp();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want finish before 100000");
        $fatal(1);
    end
endmodule
